// File: rtl/nes_controller_port_ps2.sv
// nes_controller_port_ps2
//
// Turns a raw PS/2 Set-2 scan-code byte stream into two NES controllers and
// presents their serial shift-register behaviour at CPU registers $4016/$4017.
//
// Ports:
//   clock           CPU clock; all state updates on the rising edge
//   reset           asynchronous, active-high; clears all state
//   ps2_byte        received scan-code byte
//   ps2_byte_valid  one-cycle pulse qualifying ps2_byte
//   strobe          level, bit0 of the last CPU write to $4016
//   read_4016       one-cycle pulse per completed CPU read of $4016
//   read_4017       one-cycle pulse per completed CPU read of $4017
//   reg_4016        open_bus_bits | P1 serial bit
//   reg_4017        open_bus_bits | P2 serial bit
//   buttons_p1      live P1 button state (debug)
//   buttons_p2      live P2 button state (debug)
//   protocol_error  sticky, set by an illegal prefix sequence
//   fsm_state       prefix FSM state (debug): 0 IDLE, 1 EXT, 2 BRK, 3 EXT_BRK, 4 SKIP
//
// Handshake: ps2_byte is consumed in exactly the cycle ps2_byte_valid is high;
// there is no ready/back-pressure, every valid byte is accepted.
//
// Button bit order (also shift order, bit0 first):
//   0=A 1=B 2=Select 3=Start 4=Up 5=Down 6=Left 7=Right

module nes_controller_port_ps2 #(
    parameter logic [7:0] open_bus_bits = 8'h40,
    parameter int         skip_len      = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_valid,
    input  logic       strobe,
    input  logic       read_4016,
    input  logic       read_4017,
    output logic [7:0] reg_4016,
    output logic [7:0] reg_4017,
    output logic [7:0] buttons_p1,
    output logic [7:0] buttons_p2,
    output logic       protocol_error,
    output logic [2:0] fsm_state
);

    localparam int cnt_w = $clog2(skip_len + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        SKIP    = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [cnt_w-1:0] cnt, cnt_next;
    logic             err_set;
    logic             do_make, do_break, is_ext;
    logic [7:0]       mask_p1, mask_p2;
    logic [7:0]       sr1, sr2;
    logic             is_prefix, is_ctrl;

    function automatic logic [7:0] map_p1(input logic [7:0] code, input logic ext);
        logic [7:0] m;
        m = 8'h00;
        if (!ext) begin
            case (code)
                8'h42:   m = 8'h01;
                8'h3B:   m = 8'h02;
                8'h59:   m = 8'h04;
                8'h5A:   m = 8'h08;
                8'h1D:   m = 8'h10;
                8'h1B:   m = 8'h20;
                8'h1C:   m = 8'h40;
                8'h23:   m = 8'h80;
                default: m = 8'h00;
            endcase
        end
        return m;
    endfunction

    function automatic logic [7:0] map_p2(input logic [7:0] code, input logic ext);
        logic [7:0] m;
        m = 8'h00;
        if (!ext) begin
            case (code)
                8'h69:   m = 8'h01;
                8'h70:   m = 8'h02;
                8'h7A:   m = 8'h04;
                default: m = 8'h00;
            endcase
        end else begin
            case (code)
                8'h5A:   m = 8'h08;
                8'h75:   m = 8'h10;
                8'h72:   m = 8'h20;
                8'h6B:   m = 8'h40;
                8'h74:   m = 8'h80;
                default: m = 8'h00;
            endcase
        end
        return m;
    endfunction

    assign is_prefix = (ps2_byte == 8'hE0) || (ps2_byte == 8'hF0) || (ps2_byte == 8'hE1);
    assign is_ctrl   = (ps2_byte == 8'hAA) || (ps2_byte == 8'hFA) || (ps2_byte == 8'hEE) ||
                       (ps2_byte == 8'hFE) || (ps2_byte == 8'h00) || (ps2_byte == 8'hFF);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            protocol_error <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (err_set) protocol_error <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_set    = 1'b0;
        if (ps2_byte_valid) begin
            case (state)
                IDLE: begin
                    if (ps2_byte == 8'hE0)      state_next = EXT;
                    else if (ps2_byte == 8'hF0) state_next = BRK;
                    else if (ps2_byte == 8'hE1) begin
                        state_next = SKIP;
                        cnt_next   = cnt_w'(skip_len);
                    end
                end
                EXT: begin
                    if (ps2_byte == 8'hF0) state_next = EXT_BRK;
                    else begin
                        state_next = IDLE;
                        err_set    = (ps2_byte == 8'hE0) || (ps2_byte == 8'hE1);
                    end
                end
                BRK, EXT_BRK: begin
                    state_next = IDLE;
                    err_set    = is_prefix;
                end
                SKIP: begin
                    // The Pause remainder itself contains E1/F0 bytes, so SKIP
                    // swallows every byte blindly rather than parsing prefixes.
                    cnt_next = cnt - cnt_w'(1);
                    if (cnt <= cnt_w'(1)) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode: make/break actions for the current byte
    always_comb begin
        do_make  = 1'b0;
        do_break = 1'b0;
        is_ext   = 1'b0;
        if (ps2_byte_valid) begin
            case (state)
                IDLE:    do_make = !is_prefix && !is_ctrl;
                EXT: begin
                    do_make = !is_prefix;
                    is_ext  = 1'b1;
                end
                BRK:     do_break = !is_prefix;
                EXT_BRK: begin
                    do_break = !is_prefix;
                    is_ext   = 1'b1;
                end
                default: begin
                    do_make  = 1'b0;
                    do_break = 1'b0;
                end
            endcase
        end
        mask_p1 = map_p1(ps2_byte, is_ext);
        mask_p2 = map_p2(ps2_byte, is_ext);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buttons_p1 <= 8'h00;
            buttons_p2 <= 8'h00;
        end else if (do_make) begin
            buttons_p1 <= buttons_p1 | mask_p1;
            buttons_p2 <= buttons_p2 | mask_p2;
        end else if (do_break) begin
            buttons_p1 <= buttons_p1 & ~mask_p1;
            buttons_p2 <= buttons_p2 & ~mask_p2;
        end
    end

    // Controller shift registers: strobe reloads and overrides any read;
    // otherwise each read shifts right with 1s filling from the top.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr1 <= 8'h00;
            sr2 <= 8'h00;
        end else if (strobe) begin
            sr1 <= buttons_p1;
            sr2 <= buttons_p2;
        end else begin
            if (read_4016) sr1 <= {1'b1, sr1[7:1]};
            if (read_4017) sr2 <= {1'b1, sr2[7:1]};
        end
    end

    assign reg_4016  = open_bus_bits | {7'b0, sr1[0]};
    assign reg_4017  = open_bus_bits | {7'b0, sr2[0]};
    assign fsm_state = state;

endmodule

// File: tb/tb_nes_controller_port_ps2.sv
// tb_nes_controller_port_ps2
//
// Directed bench for nes_controller_port_ps2. Expected values are pushed onto
// exp_q when stimulus is driven and popped when the DUT output is sampled.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_nes_controller_port_ps2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ps2_byte = 8'h00;
    logic       ps2_byte_valid = 1'b0;
    logic       strobe = 1'b0;
    logic       read_4016 = 1'b0;
    logic       read_4017 = 1'b0;
    logic [7:0] reg_4016, reg_4017, buttons_p1, buttons_p2;
    logic       protocol_error;
    logic [2:0] fsm_state;

    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    nes_controller_port_ps2 dut (
        .clock          (clock),
        .reset          (reset),
        .ps2_byte       (ps2_byte),
        .ps2_byte_valid (ps2_byte_valid),
        .strobe         (strobe),
        .read_4016      (read_4016),
        .read_4017      (read_4017),
        .reg_4016       (reg_4016),
        .reg_4017       (reg_4017),
        .buttons_p1     (buttons_p1),
        .buttons_p2     (buttons_p2),
        .protocol_error (protocol_error),
        .fsm_state      (fsm_state)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        ps2_byte       = b;
        ps2_byte_valid = 1'b1;
        @(negedge clock);
        ps2_byte_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] a, input logic [7:0] b);
        send_byte(a);
        send_byte(b);
    endtask

    task automatic strobe_pulse();
        @(negedge clock);
        strobe = 1'b1;
        @(negedge clock);
        strobe = 1'b0;
    endtask

    task automatic read_pulse(input logic r16, input logic r17);
        @(negedge clock);
        read_4016 = r16;
        read_4017 = r17;
        @(negedge clock);
        read_4016 = 1'b0;
        read_4017 = 1'b0;
    endtask

    // Scoreboard
    task automatic expect_val(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: observed %h with empty expected queue", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        expect_val(8'h40); check({tag, "_reg4016"}, reg_4016);
        expect_val(8'h40); check({tag, "_reg4017"}, reg_4017);
        expect_val(8'h00); check({tag, "_p1"}, buttons_p1);
        expect_val(8'h00); check({tag, "_p2"}, buttons_p2);
        expect_val(8'h00); check({tag, "_err"}, {7'b0, protocol_error});
        expect_val(8'h00); check({tag, "_state"}, {5'b0, fsm_state});
    endtask

    initial begin
        logic [7:0] p1_serial;

        // Reset
        repeat (2) @(negedge clock);
        check_reset_state("reset");
        reset = 1'b0;

        // Makes K and Enter, then serial readout of P1
        send_byte(8'h42);
        expect_val(8'h01); check("make_k", buttons_p1);
        send_byte(8'h5A);
        expect_val(8'h09); check("make_enter", buttons_p1);
        send_byte(8'h42);
        expect_val(8'h09); check("repeat_make", buttons_p1);
        strobe_pulse();
        expect_val(8'h40); check("p2_after_strobe", reg_4017);
        p1_serial = 8'h09;
        for (int i = 0; i < 10; i++) begin
            expect_val(8'h40 | {7'b0, (i < 8) ? p1_serial[i] : 1'b1});
            check($sformatf("serial_p1_%0d", i), reg_4016);
            read_pulse(1'b1, 1'b0);
        end

        // Extended P2 Up make/break, non-extended 75/72 unmapped
        send_byte(8'hE0);
        expect_val(8'h00); check("ext_prefix_only", buttons_p2);
        expect_val(8'h01); check("state_ext", {5'b0, fsm_state});
        send_byte(8'h75);
        expect_val(8'h10); check("ext_make_up", buttons_p2);
        send_byte(8'hE0);
        send_byte(8'hF0);
        expect_val(8'h03); check("state_ext_brk", {5'b0, fsm_state});
        send_byte(8'h75);
        expect_val(8'h00); check("ext_break_up", buttons_p2);
        expect_val(8'h09); check("p1_untouched", buttons_p1);
        send_byte(8'h75);
        expect_val(8'h00); check("nonext_75", buttons_p2);
        send_byte(8'h72);
        expect_val(8'h00); check("nonext_72", buttons_p2);
        send_byte(8'hAA);
        expect_val(8'h00); check("ctrl_byte_state", {5'b0, fsm_state});

        // Release P1 keys
        send_seq(8'hF0, 8'h42);
        send_seq(8'hF0, 8'h5A);
        expect_val(8'h00); check("p1_released", buttons_p1);

        // Strobe held: reads do not shift
        @(negedge clock);
        strobe = 1'b1;
        send_byte(8'h42);
        @(negedge clock);
        expect_val(8'h41); check("strobe_load", reg_4016);
        for (int i = 0; i < 3; i++) begin
            read_pulse(1'b1, 1'b0);
            expect_val(8'h41); check($sformatf("strobe_hold_read_%0d", i), reg_4016);
        end
        @(negedge clock);
        strobe = 1'b0;
        read_pulse(1'b1, 1'b0);
        expect_val(8'h40); check("after_strobe_read", reg_4016);

        // Simultaneous reads on both ports
        send_byte(8'h69);
        expect_val(8'h01); check("make_kp1", buttons_p2);
        strobe_pulse();
        expect_val(8'h41); check("sim_pre_4016", reg_4016);
        expect_val(8'h41); check("sim_pre_4017", reg_4017);
        read_pulse(1'b1, 1'b1);
        expect_val(8'h40); check("sim_post_4016", reg_4016);
        expect_val(8'h40); check("sim_post_4017", reg_4017);
        send_seq(8'hF0, 8'h42);
        send_seq(8'hF0, 8'h69);

        // Illegal prefix F0 F0
        send_byte(8'hF0);
        send_byte(8'hF0);
        expect_val(8'h01); check("err_set", {7'b0, protocol_error});
        expect_val(8'h00); check("err_idle", {5'b0, fsm_state});
        send_byte(8'h1C);
        expect_val(8'h40); check("make_after_err", buttons_p1);
        send_seq(8'hE0, 8'hE0);
        expect_val(8'h01); check("err_sticky", {7'b0, protocol_error});
        send_seq(8'hF0, 8'h1C);
        expect_val(8'h00); check("break_a_key", buttons_p1);

        // Pause sequence skip
        send_byte(8'hE1);
        expect_val(8'h04); check("state_skip", {5'b0, fsm_state});
        send_byte(8'h14); send_byte(8'h77); send_byte(8'h42); send_byte(8'hF0);
        send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        expect_val(8'h00); check("skip_no_change", buttons_p1);
        expect_val(8'h00); check("skip_done_idle", {5'b0, fsm_state});
        send_byte(8'h23);
        expect_val(8'h80); check("make_after_skip", buttons_p1);

        // All P1 buttons held, then reset mid-break
        send_byte(8'h42); send_byte(8'h3B); send_byte(8'h59); send_byte(8'h5A);
        send_byte(8'h1D); send_byte(8'h1B); send_byte(8'h1C);
        expect_val(8'hFF); check("p1_all", buttons_p1);
        strobe_pulse();
        expect_val(8'h41); check("p1_all_serial", reg_4016);
        send_byte(8'hF0);
        expect_val(8'h02); check("state_brk", {5'b0, fsm_state});
        @(negedge clock);
        #2 reset = 1'b1;
        #1 check_reset_state("async_reset");
        @(negedge clock);
        reset = 1'b0;
        send_byte(8'h1C);
        expect_val(8'h40); check("make_after_reset", buttons_p1);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover_expectations: observed %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
